lcd_text_sequencer: RTL
=======================

// Module: lcd_text_sequencer
// PURPOSE
//  Drives the character LCD write controller to run the HD44780 power-up init, then refresh a 2x16 text frame.
//  Host logic writes characters into an internal 32-byte buffer and pulses iUpdate; the block issues one
//  byte-write transaction at a time to the LCD write controller (start/done handshake) and enforces command gaps.
// PARAMETERS
//  POWERUP_CYCLES  750000  idle cycles after reset before first command (15 ms @ 50 MHz)
//  GAP_CYCLES      2500    idle cycles after every normal command/char (50 us)
//  CLEAR_CYCLES    100000  idle cycles after the clear command 0x01 (2 ms)
//  REFRESH_CYCLES  5000000 auto-refresh period (LCD_AUTO_REFRESH_EN only)
// PORTS
//  iCLK        in   1  system clock
//  iRST        in   1  synchronous active-high reset
//  iWrEn       in   1  buffer write strobe
//  iWrAddr     in   5  buffer index: 0-15 line 1, 16-31 line 2
//  iWrData     in   8  character code
//  iUpdate     in   1  request frame refresh (level sampled each cycle)
//  oReady      out  1  init sequence complete
//  oBusy       out  1  init or refresh in progress
//  oLCD_DATA   out  8  byte to LCD write controller
//  oLCD_RS     out  1  0 = command, 1 = character
//  oLCD_START  out  1  transaction start (controller is rising-edge triggered)
//  iLCD_DONE   in   1  controller done (stays high until next start)
// BEHAVIOUR
//  Reset: oReady=0, oBusy=1, oLCD_START=0, oLCD_DATA=0x00, oLCD_RS=0, pending=0, buffer all 0x20; FSM -> PWR_WAIT.
//  Reset mid-transaction: same values; the sequence restarts from PWR_WAIT, and no partial state is kept.
//  FSM: PWR_WAIT -> INIT -> IDLE; IDLE -> L1_ADDR -> L1_CHR -> L2_ADDR -> L2_CHR -> IDLE.
//  Each byte uses sub-states ISSUE -> WAIT_LOW -> WAIT_HIGH -> GAP:
//   ISSUE: register data/RS, set oLCD_START=1.
//   WAIT_LOW: hold until iLCD_DONE==0, acknowledging the start.
//   WAIT_HIGH: hold until iLCD_DONE==1, then oLCD_START=0.
//   GAP: count GAP_CYCLES, or CLEAR_CYCLES after 0x01, then go to the next byte.
//  oLCD_DATA/oLCD_RS stay stable from ISSUE through the end of WAIT_HIGH.
//  INIT bytes (RS=0), in order: 0x38, 0x0C, 0x01, 0x06. Then oReady=1 and oBusy=0 in the cycle IDLE is entered.
//  Refresh, in order:
//   - cmd 0x80 (RS=0), then chars buf[0..15] (RS=1);
//   - cmd 0xC0 (RS=0), then chars buf[16..31] (RS=1).
//   - Total 34 transactions.
//  iUpdate in IDLE starts a refresh the next cycle; oBusy=1 from that cycle until return to IDLE.
//  iUpdate while oBusy (incl. init): sets pending. On return to IDLE, a pending refresh starts immediately and
//   clears pending. Multiple requests coalesce into one.
//  Buffer writes accepted every cycle in any state, including reset-exit. A char is read at its ISSUE cycle;
//   a same-cycle write to that index is seen on the next refresh, not this one.
//  Gap counter: width $clog2(max(POWERUP_CYCLES,CLEAR_CYCLES,GAP_CYCLES)+1), saturating, cleared on each GAP entry.
//  Char index: 5-bit, wraps 15->16 via the L2_ADDR step, never beyond 31.
// CONFIGURATION
//  LCD_AUTO_REFRESH_EN defined: a free-running counter, reset to 0, sets pending every REFRESH_CYCLES cycles
//   while oReady=1. Counter keeps running during refresh.
//  LCD_AUTO_REFRESH_EN undefined: a refresh happens only via iUpdate; no counter is built.
// STRUCTURE
//  Package lcd_seq_pkg:
//   - state enum (top and byte sub-states);
//   - LCD_CMD_FUNC=0x38, LCD_CMD_DISP=0x0C, LCD_CMD_CLEAR=0x01, LCD_CMD_ENTRY=0x06;
//   - LCD_CMD_LINE1=0x80, LCD_CMD_LINE2=0xC0, LCD_CHARS=32.
//  Sub-module lcd_char_buffer: 32x8 register file. Sync write, async read, sync reset to 0x20.
// TESTING
//  Use small params: POWERUP=20, GAP=4, CLEAR=10. Pair the block with the LCD write controller (CLK_Divide=4)
//  and invert reset for the controller.
//  1. Reset release: first start rising edge at cycle >=20. Bytes 0x38,0x0C,0x01,0x06 all RS=0.
//     Gap after 0x01 >=10 cycles. oReady rises after the 4th done.
//  2. Write "HELLO" at 0-4, pulse iUpdate:
//     - 0x80 RS=0, then 48,45,4C,4C,4F, then 11x 0x20 RS=1;
//     - 0xC0 RS=0, then 16x 0x20.
//     34 transactions total, then oBusy=0.
//  3. Pulse iUpdate 3x during a refresh: exactly one extra refresh (34 more transactions), then IDLE.
//  4. Assert iRST during the 10th refresh char: outputs reach reset values next cycle, full init replays,
//     buffer reads back all 0x20.
//  5. Write 0x41 to index 5 in the same cycle that index 5 is issued: this refresh sends 0x20, the next sends 0x41.
//  6. LCD_AUTO_REFRESH_EN with REFRESH_CYCLES=300: refreshes start without iUpdate, about every 300 cycles
//     after oReady. None start before oReady.

Source files
------------

// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the LCD text sequencer: state encodings,
// HD44780 command bytes and the init-sequence lookup.
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_L1_ADDR,
    ST_L1_CHR,
    ST_L2_ADDR,
    ST_L2_CHR
  } seq_state_e;

  typedef enum logic [1:0] {
    SUB_ISSUE,
    SUB_WAIT_LOW,
    SUB_WAIT_HIGH,
    SUB_GAP
  } byte_state_e;

  localparam logic [7:0] LCD_CMD_FUNC  = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY = 8'h06;
  localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
  localparam logic [7:0] LCD_SPACE     = 8'h20;
  localparam int unsigned LCD_CHARS    = 32;

  function automatic logic [7:0] init_byte(input logic [1:0] step);
    logic [7:0] b;
    unique case (step)
      2'd0: b = LCD_CMD_FUNC;
      2'd1: b = LCD_CMD_DISP;
      2'd2: b = LCD_CMD_CLEAR;
      2'd3: b = LCD_CMD_ENTRY;
    endcase
    return b;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_text_sequencer_if.sv
// Byte-write handshake between the text sequencer (master) and the
// character LCD write controller (slave).
interface lcd_text_sequencer_if;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_START;
  logic       LCD_DONE;

  modport master (output LCD_DATA, output LCD_RS, output LCD_START, input LCD_DONE);
  modport slave  (input LCD_DATA, input LCD_RS, input LCD_START, output LCD_DONE);
endinterface

// File: rtl/lcd_char_buffer.sv
// 32x8 text frame register file: synchronous write, asynchronous read,
// synchronous reset to ASCII space.
module lcd_char_buffer
  import lcd_seq_pkg::*;
(
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iWrEn,
  input  logic [4:0] iWrAddr,
  input  logic [7:0] iWrData,
  input  logic [4:0] iRdAddr,
  output logic [7:0] oRdData
);

  logic [7:0] mem_q [LCD_CHARS];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int unsigned i = 0; i < LCD_CHARS; i++) mem_q[5'(i)] <= LCD_SPACE;
    end else if (iWrEn) begin
      mem_q[iWrAddr] <= iWrData;
    end
  end

  assign oRdData = mem_q[iRdAddr];

endmodule

// File: rtl/lcd_text_sequencer.sv
// HD44780 power-up init followed by on-demand 2x16 frame refresh, one byte per
// start/done transaction. Optional periodic refresh: define LCD_AUTO_REFRESH_EN.
module lcd_text_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter int unsigned GAP_CYCLES     = 2500,
  parameter int unsigned CLEAR_CYCLES   = 100000
`ifdef LCD_AUTO_REFRESH_EN
  ,
  parameter int unsigned REFRESH_CYCLES = 5000000
`endif
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iWrEn,
  input  logic [4:0]           iWrAddr,
  input  logic [7:0]           iWrData,
  input  logic                 iUpdate,
  output logic                 oReady,
  output logic                 oBusy,
  lcd_text_sequencer_if.master lcd
);

  localparam int unsigned CNT_W = $clog2(max3(POWERUP_CYCLES, CLEAR_CYCLES, GAP_CYCLES) + 1);

  seq_state_e       state_q, state_d;
  byte_state_e      sub_q, sub_d;
  logic [1:0]       step_q, step_d;
  logic [4:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             start_q, start_d;
  logic [7:0]       rd_data, byte_sel;
  logic [CNT_W-1:0] gap_last;
  logic             busy, refresh_req;

  lcd_char_buffer u_buf (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iWrEn   (iWrEn),
    .iWrAddr (iWrAddr),
    .iWrData (iWrData),
    .iRdAddr (idx_q),
    .oRdData (rd_data)
  );

  assign busy = (state_q != ST_IDLE);

`ifdef LCD_AUTO_REFRESH_EN
  localparam int unsigned REF_W = $clog2(REFRESH_CYCLES + 1);
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             ref_tick;

  always_comb begin
    ref_tick  = (ref_cnt_q == REF_W'(REFRESH_CYCLES - 1));
    ref_cnt_d = ref_tick ? '0 : ref_cnt_q + 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) ref_cnt_q <= '0;
    else      ref_cnt_q <= ref_cnt_d;
  end

  assign refresh_req = iUpdate | (ref_tick & oReady);
`else
  assign refresh_req = iUpdate;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_PWR_WAIT;
      sub_q     <= SUB_ISSUE;
      step_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      data_q    <= '0;
      rs_q      <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      step_q    <= step_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      rs_q      <= rs_d;
      start_q   <= start_d;
    end
  end

  always_comb begin
    unique case (state_q)
      ST_INIT:    byte_sel = init_byte(step_q);
      ST_L1_ADDR: byte_sel = LCD_CMD_LINE1;
      ST_L2_ADDR: byte_sel = LCD_CMD_LINE2;
      default:    byte_sel = rd_data;
    endcase
    // The clear command needs the long settle time; a 0x01 character does not.
    gap_last = (!rs_q && data_q == LCD_CMD_CLEAR) ? CNT_W'(CLEAR_CYCLES - 1)
                                                  : CNT_W'(GAP_CYCLES - 1);
  end

  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    step_d    = step_q;
    idx_d     = idx_q;
    cnt_d     = (cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    pending_d = pending_q;
    data_d    = data_q;
    rs_d      = rs_q;
    start_d   = start_q;
    if (refresh_req && busy) pending_d = 1'b1;

    unique case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_q >= CNT_W'(POWERUP_CYCLES - 1)) begin
          state_d = ST_INIT;
          sub_d   = SUB_ISSUE;
          step_d  = '0;
        end
      end
      ST_IDLE: begin
        if (refresh_req || pending_q) begin
          state_d   = ST_L1_ADDR;
          sub_d     = SUB_ISSUE;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      default: begin
        unique case (sub_q)
          SUB_ISSUE: begin
            data_d  = byte_sel;
            rs_d    = (state_q == ST_L1_CHR) || (state_q == ST_L2_CHR);
            start_d = 1'b1;
            sub_d   = SUB_WAIT_LOW;
          end
          SUB_WAIT_LOW: if (!lcd.LCD_DONE) sub_d = SUB_WAIT_HIGH;
          SUB_WAIT_HIGH: begin
            if (lcd.LCD_DONE) begin
              start_d = 1'b0;
              sub_d   = SUB_GAP;
              cnt_d   = '0;
            end
          end
          SUB_GAP: begin
            if (cnt_q >= gap_last) begin
              sub_d = SUB_ISSUE;
              unique case (state_q)
                ST_INIT: begin
                  if (step_q == 2'd3) state_d = ST_IDLE;
                  else                step_d  = step_q + 1'b1;
                end
                ST_L1_ADDR: state_d = ST_L1_CHR;
                ST_L1_CHR: begin
                  idx_d = idx_q + 5'd1;
                  if (idx_q == 5'd15) state_d = ST_L2_ADDR;
                end
                ST_L2_ADDR: state_d = ST_L2_CHR;
                ST_L2_CHR: begin
                  if (idx_q == 5'd31) state_d = ST_IDLE;
                  else                idx_d   = idx_q + 5'd1;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    endcase
  end

  always_comb begin
    oReady        = !(state_q inside {ST_PWR_WAIT, ST_INIT});
    oBusy         = busy;
    lcd.LCD_DATA  = data_q;
    lcd.LCD_RS    = rs_q;
    lcd.LCD_START = start_q;
  end

endmodule
